exec_datapath: RTL and testbench

Command responder for the switch-driven CPU: accepts the decoded fields and single-cycle enable strobes issued by the control FSM, reads operands from a 16-entry register file, executes the operation, writes back, and hands a display record to the LCD driver. Once that record is accepted it returns a single-cycle `store_done` pulse, which releases the control FSM from its STORE state back to IDLE.

---
 rtl/cpu_pkg.sv | 32 +++
 rtl/reg_file.sv | 49 ++++
 rtl/exec_datapath.sv | 215 +++++++++++++++++++++
 tb/tb_exec_datapath.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the switch-driven CPU: opcode encoding (also used by the
// control FSM), datapath sequencer states and the default data width.
package cpu_pkg;

  localparam int unsigned DataW = 16;

  typedef enum logic [2:0] {
    OpLoad    = 3'd0,
    OpAdd     = 3'd1,
    OpAddi    = 3'd2,
    OpSub     = 3'd3,
    OpSubi    = 3'd4,
    OpMul     = 3'd5,
    OpClear   = 3'd6,
    OpDisplay = 3'd7
  } op_e;

  typedef enum logic [2:0] {
    StIdle,
    StRead,
    StExec,
    StWrite,
    StSend,
    StDone
  } state_e;

  // Opcodes whose result lands in rf[DEST]
  function automatic logic op_writes_rf(op_e op);
    return (op != OpClear) && (op != OpDisplay);
  endfunction

endpackage

// File: rtl/reg_file.sv
// Register file: RegCnt x DataW storage.
//   raddr_a_i/rdata_a_o, raddr_b_i/rdata_b_o : asynchronous read ports
//   we_i/waddr_i/wdata_i                     : synchronous write port
//   clr_i/clr_idx_i                          : synchronous zeroing of one entry
//   rst_ni                                   : asynchronous active-low reset, all entries to 0
module reg_file #(
  parameter  int unsigned DataW  = 16,
  parameter  int unsigned RegCnt = 16,
  localparam int unsigned IdxW   = $clog2(RegCnt)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [IdxW-1:0]  raddr_a_i,
  output logic [DataW-1:0] rdata_a_o,
  input  logic [IdxW-1:0]  raddr_b_i,
  output logic [DataW-1:0] rdata_b_o,
  input  logic             we_i,
  input  logic [IdxW-1:0]  waddr_i,
  input  logic [DataW-1:0] wdata_i,
  input  logic             clr_i,
  input  logic [IdxW-1:0]  clr_idx_i
);

  logic [DataW-1:0] mem_q [RegCnt];
  logic [DataW-1:0] mem_d [RegCnt];

  assign rdata_a_o = mem_q[raddr_a_i];
  assign rdata_b_o = mem_q[raddr_b_i];

  always_comb begin
    mem_d = mem_q;
    if (clr_i) begin
      mem_d[clr_idx_i] = '0;
    end else if (we_i) begin
      mem_d[waddr_i] = wdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < RegCnt; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

endmodule

// File: rtl/exec_datapath.sv
// Command responder for the switch-driven CPU. Captures a command on any enable
// strobe in IDLE, then steps READ -> EXEC -> WRITE -> SEND -> DONE.
//   clk, rst (async active-low)
//   DEST/SRC1/SRC2, IMM_SIGN/IMM_MAGNETUDE, alu_func : command fields
//   alu_enable/read_enable/write_enable/clear_mem    : command strobes (ORed)
//   store_done : one-cycle pulse in DONE;  busy : state != IDLE
//   disp_valid/disp_ready + disp_op/reg/value/ovf     : display record handshake
module exec_datapath
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W  = DataW,
  parameter int unsigned REG_CNT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        DEST,
  input  logic [3:0]        SRC1,
  input  logic [3:0]        SRC2,
  input  logic              IMM_SIGN,
  input  logic [5:0]        IMM_MAGNETUDE,
  input  logic [2:0]        alu_func,
  input  logic              alu_enable,
  input  logic              read_enable,
  input  logic              write_enable,
  input  logic              clear_mem,
  output logic              store_done,
  output logic              busy,
  output logic              disp_valid,
  input  logic              disp_ready,
  output logic [2:0]        disp_op,
  output logic [3:0]        disp_reg,
  output logic [DATA_W-1:0] disp_value,
  output logic              disp_ovf
);

  localparam int unsigned IdxW = 4;
  localparam int unsigned Msb  = DATA_W - 1;

  state_e            state_q, state_d;
  op_e               op_q, op_d;
  logic [IdxW-1:0]   dest_q, dest_d, src1_q, src1_d, src2_q, src2_d, cnt_q, cnt_d;
  logic [DATA_W-1:0] imm_q, imm_d, opa_q, opa_d, opb_q, opb_d, res_q, res_d;
  logic              ovf_q, ovf_d;
  logic              valid_q, valid_d, rec_ovf_q, rec_ovf_d;
  op_e               rec_op_q, rec_op_d;
  logic [IdxW-1:0]   rec_reg_q, rec_reg_d;
  logic [DATA_W-1:0] rec_val_q, rec_val_d;

  logic                  strobe, rf_we, rf_clr, exec_ovf;
  logic [DATA_W-1:0]     mag_ext, rdata_a, rdata_b, exec_res, add_b, sum, diff;
  logic [2*DATA_W-1:0]   prod;

  assign strobe  = alu_enable | read_enable | write_enable | clear_mem;
  assign mag_ext = {{(DATA_W-6){1'b0}}, IMM_MAGNETUDE};

  reg_file #(
    .DataW  (DATA_W),
    .RegCnt (REG_CNT)
  ) u_reg_file (
    .clk_i     (clk),
    .rst_ni    (rst),
    .raddr_a_i (src1_q),
    .rdata_a_o (rdata_a),
    .raddr_b_i (src2_q),
    .rdata_b_o (rdata_b),
    .we_i      (rf_we),
    .waddr_i   (dest_q),
    .wdata_i   (res_q),
    .clr_i     (rf_clr),
    .clr_idx_i (cnt_q)
  );

  // ALU on the registered operands
  always_comb begin
    add_b    = ((op_q == OpAdd) || (op_q == OpSub)) ? opb_q : imm_q;
    sum      = opa_q + add_b;
    diff     = opa_q - add_b;
    prod     = $signed({{DATA_W{opa_q[Msb]}}, opa_q}) * $signed({{DATA_W{imm_q[Msb]}}, imm_q});
    exec_res = '0;
    exec_ovf = 1'b0;
    unique case (op_q)
      OpLoad: exec_res = imm_q;
      OpAdd, OpAddi: begin
        exec_res = sum;
        exec_ovf = (opa_q[Msb] == add_b[Msb]) && (sum[Msb] != opa_q[Msb]);
      end
      OpSub, OpSubi: begin
        exec_res = diff;
        exec_ovf = (opa_q[Msb] != add_b[Msb]) && (diff[Msb] != opa_q[Msb]);
      end
      OpMul: begin
        exec_res = prod[Msb:0];
        // Representable only if the upper half is a pure sign extension of bit Msb
        exec_ovf = !((&prod[2*DATA_W-1:Msb]) || !(|prod[2*DATA_W-1:Msb]));
      end
      OpClear:   exec_res = '0;
      OpDisplay: exec_res = opa_q;
      default: ;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    dest_d    = dest_q;
    src1_d    = src1_q;
    src2_d    = src2_q;
    imm_d     = imm_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    res_d     = res_q;
    ovf_d     = ovf_q;
    cnt_d     = cnt_q;
    valid_d   = valid_q;
    rec_op_d  = rec_op_q;
    rec_reg_d = rec_reg_q;
    rec_val_d = rec_val_q;
    rec_ovf_d = rec_ovf_q;
    rf_we     = 1'b0;
    rf_clr    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (strobe) begin
          op_d    = op_e'(alu_func);
          dest_d  = DEST;
          src1_d  = SRC1;
          src2_d  = SRC2;
          imm_d   = IMM_SIGN ? -mag_ext : mag_ext;
          state_d = StRead;
        end
      end
      StRead: begin
        opa_d   = rdata_a;
        opb_d   = rdata_b;
        state_d = StExec;
      end
      StExec: begin
        res_d   = exec_res;
        ovf_d   = exec_ovf;
        state_d = StWrite;
      end
      StWrite: begin
        if (op_q == OpClear) begin
          rf_clr = 1'b1;
          cnt_d  = cnt_q + IdxW'(1);
        end else begin
          rf_we = op_writes_rf(op_q);
        end
        if ((op_q != OpClear) || (cnt_q == IdxW'(REG_CNT - 1))) begin
          valid_d   = 1'b1;
          rec_op_d  = op_q;
          rec_reg_d = (op_q == OpDisplay) ? src1_q : (op_q == OpClear) ? '0 : dest_q;
          rec_val_d = res_q;
          rec_ovf_d = ovf_q;
          state_d   = StSend;
        end
      end
      StSend: begin
        if (disp_ready) begin
          valid_d = 1'b0;
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      op_q      <= OpLoad;
      dest_q    <= '0;
      src1_q    <= '0;
      src2_q    <= '0;
      imm_q     <= '0;
      opa_q     <= '0;
      opb_q     <= '0;
      res_q     <= '0;
      ovf_q     <= 1'b0;
      cnt_q     <= '0;
      valid_q   <= 1'b0;
      rec_op_q  <= OpLoad;
      rec_reg_q <= '0;
      rec_val_q <= '0;
      rec_ovf_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      dest_q    <= dest_d;
      src1_q    <= src1_d;
      src2_q    <= src2_d;
      imm_q     <= imm_d;
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      res_q     <= res_d;
      ovf_q     <= ovf_d;
      cnt_q     <= cnt_d;
      valid_q   <= valid_d;
      rec_op_q  <= rec_op_d;
      rec_reg_q <= rec_reg_d;
      rec_val_q <= rec_val_d;
      rec_ovf_q <= rec_ovf_d;
    end
  end

  assign busy       = (state_q != StIdle);
  assign store_done = (state_q == StDone);
  assign disp_valid = valid_q;
  assign disp_op    = rec_op_q;
  assign disp_reg   = rec_reg_q;
  assign disp_value = rec_val_q;
  assign disp_ovf   = rec_ovf_q;

endmodule

// File: tb/tb_exec_datapath.sv
// Directed bench for exec_datapath: hand-computed records, timing and handshake checks.
module tb_exec_datapath;

  localparam logic [2:0] LD = 3'd0, ADD = 3'd1, ADDI = 3'd2, SUB = 3'd3, SUBI = 3'd4,
                         MUL = 3'd5, CLR = 3'd6, DSP = 3'd7;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  DEST = '0, SRC1 = '0, SRC2 = '0;
  logic        IMM_SIGN = 1'b0;
  logic [5:0]  IMM_MAGNETUDE = '0;
  logic [2:0]  alu_func = '0;
  logic        alu_enable = 1'b0, read_enable = 1'b0, write_enable = 1'b0, clear_mem = 1'b0;
  logic        store_done, busy, disp_valid, disp_ovf;
  logic        disp_ready = 1'b1;
  logic [2:0]  disp_op;
  logic [3:0]  disp_reg;
  logic [15:0] disp_value;

  int n_tests = 0;
  int n_fail  = 0;

  exec_datapath dut (
    .clk           (clk),
    .rst           (rst),
    .DEST          (DEST),
    .SRC1          (SRC1),
    .SRC2          (SRC2),
    .IMM_SIGN      (IMM_SIGN),
    .IMM_MAGNETUDE (IMM_MAGNETUDE),
    .alu_func      (alu_func),
    .alu_enable    (alu_enable),
    .read_enable   (read_enable),
    .write_enable  (write_enable),
    .clear_mem     (clear_mem),
    .store_done    (store_done),
    .busy          (busy),
    .disp_valid    (disp_valid),
    .disp_ready    (disp_ready),
    .disp_op       (disp_op),
    .disp_reg      (disp_reg),
    .disp_value    (disp_value),
    .disp_ovf      (disp_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pulses one enable for one cycle; returns at the negedge of T+1.
  task automatic issue(input logic [2:0] f, input logic [3:0] d, input logic [3:0] s1,
                       input logic [3:0] s2, input logic sg, input logic [5:0] m,
                       input int en_sel);
    @(negedge clk);
    alu_func = f; DEST = d; SRC1 = s1; SRC2 = s2; IMM_SIGN = sg; IMM_MAGNETUDE = m;
    case (en_sel)
      0:       alu_enable   = 1'b1;
      1:       read_enable  = 1'b1;
      2:       write_enable = 1'b1;
      default: clear_mem    = 1'b1;
    endcase
    @(negedge clk);
    alu_enable = 1'b0; read_enable = 1'b0; write_enable = 1'b0; clear_mem = 1'b0;
  endtask

  // Runs one command; done_k is the cycle offset (from T) of store_done. Returns in IDLE.
  task automatic run(input logic [2:0] f, input logic [3:0] d, input logic [3:0] s1,
                     input logic [3:0] s2, input logic sg, input logic [5:0] m,
                     output logic [2:0] r_op, output logic [3:0] r_reg,
                     output logic [15:0] r_val, output logic r_ovf, output int done_k);
    int k;
    r_op = 'x; r_reg = 'x; r_val = 'x; r_ovf = 'x;
    done_k = -1;
    k = 1;
    issue(f, d, s1, s2, sg, m, int'(f) % 4);
    while (k < 60) begin
      if (disp_valid && disp_ready) begin
        r_op = disp_op; r_reg = disp_reg; r_val = disp_value; r_ovf = disp_ovf;
      end
      if (store_done) begin
        done_k = k;
        break;
      end
      @(negedge clk);
      k++;
    end
    if (done_k < 0) chk("store_done_timeout", 32'd0, 32'd1);
    @(negedge clk);
  endtask

  task automatic cmd(input string tag, input logic [2:0] f, input logic [3:0] d,
                     input logic [3:0] s1, input logic [3:0] s2, input logic sg,
                     input logic [5:0] m, input logic [3:0] e_reg, input logic [15:0] e_val,
                     input logic e_ovf, input int e_k);
    logic [2:0]  r_op;
    logic [3:0]  r_reg;
    logic [15:0] r_val;
    logic        r_ovf;
    int          k;
    run(f, d, s1, s2, sg, m, r_op, r_reg, r_val, r_ovf, k);
    chk({tag, "_op"}, r_op, f);
    chk({tag, "_reg"}, r_reg, e_reg);
    chk({tag, "_val"}, r_val, e_val);
    chk({tag, "_ovf"}, r_ovf, e_ovf);
    chk({tag, "_lat"}, k, e_k);
  endtask

  task automatic quiet(input logic [2:0] f, input logic [3:0] d, input logic [3:0] s1,
                       input logic [3:0] s2, input logic sg, input logic [5:0] m);
    logic [2:0]  r_op;
    logic [3:0]  r_reg;
    logic [15:0] r_val;
    logic        r_ovf;
    int          k;
    run(f, d, s1, s2, sg, m, r_op, r_reg, r_val, r_ovf, k);
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_store_done", store_done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_valid", disp_valid, 0);
    chk("rst_value", disp_value, 0);
    @(negedge clk);
    rst = 1'b1;

    // LOAD r3,-5 with exact cycle timing
    issue(LD, 4'd3, 4'd0, 4'd0, 1'b1, 6'd5, 1);
    chk("ld_busy_t1", busy, 1);
    repeat (3) @(negedge clk);
    chk("ld_valid_t4", disp_valid, 1);
    chk("ld_op_t4", disp_op, 0);
    chk("ld_reg_t4", disp_reg, 3);
    chk("ld_val_t4", disp_value, 16'hFFFB);
    chk("ld_ovf_t4", disp_ovf, 0);
    chk("ld_sd_t4", store_done, 0);
    @(negedge clk);
    chk("ld_sd_t5", store_done, 1);
    chk("ld_valid_t5", disp_valid, 0);
    @(negedge clk);
    chk("ld_sd_t6", store_done, 0);
    chk("ld_busy_t6", busy, 0);

    // Build 0x7FFF through r7, then overflowing add/sub
    quiet(LD, 4'd7, 4'd0, 4'd0, 1'b0, 6'd32);
    cmd("mul1024", MUL, 4'd7, 4'd7, 4'd0, 1'b0, 6'd32, 4'd7, 16'h0400, 1'b0, 5);
    cmd("mul8000", MUL, 4'd7, 4'd7, 4'd0, 1'b0, 6'd32, 4'd7, 16'h8000, 1'b1, 5);
    cmd("subi7fff", SUBI, 4'd1, 4'd7, 4'd0, 1'b0, 6'd1, 4'd1, 16'h7FFF, 1'b1, 5);
    cmd("add_ovf", ADD, 4'd2, 4'd1, 4'd1, 1'b0, 6'd0, 4'd2, 16'hFFFE, 1'b1, 5);
    cmd("addi_ovf", ADDI, 4'd2, 4'd1, 4'd0, 1'b0, 6'd1, 4'd2, 16'h8000, 1'b1, 5);
    cmd("sub_ovf", SUB, 4'd2, 4'd1, 4'd3, 1'b0, 6'd0, 4'd2, 16'h8004, 1'b1, 5);
    cmd("sub_zero", SUB, 4'd8, 4'd3, 4'd3, 1'b0, 6'd0, 4'd8, 16'h0000, 1'b0, 5);
    cmd("subi_neg", SUBI, 4'd9, 4'd3, 4'd0, 1'b1, 6'd3, 4'd9, 16'hFFFE, 1'b0, 5);
    cmd("ld_negzero", LD, 4'd10, 4'd0, 4'd0, 1'b1, 6'd0, 4'd10, 16'h0000, 1'b0, 5);

    // Multiply cases
    quiet(LD, 4'd5, 4'd0, 4'd0, 1'b0, 6'd60);
    cmd("mul300", MUL, 4'd5, 4'd5, 4'd0, 1'b0, 6'd5, 4'd5, 16'd300, 1'b0, 5);
    cmd("mul18900", MUL, 4'd4, 4'd5, 4'd0, 1'b0, 6'd63, 4'd4, 16'h49D4, 1'b0, 5);
    quiet(LD, 4'd5, 4'd0, 4'd0, 1'b0, 6'd40);
    cmd("mul1000", MUL, 4'd5, 4'd5, 4'd0, 1'b0, 6'd25, 4'd5, 16'd1000, 1'b0, 5);
    cmd("mul63000", MUL, 4'd12, 4'd5, 4'd0, 1'b0, 6'd63, 4'd12, 16'hF618, 1'b1, 5);
    cmd("mul_neg", MUL, 4'd13, 4'd5, 4'd0, 1'b1, 6'd2, 4'd13, 16'hF830, 1'b0, 5);
    cmd("dsp_r4", DSP, 4'd0, 4'd4, 4'd0, 1'b0, 6'd0, 4'd4, 16'h49D4, 1'b0, 5);

    // Fill r0..r15, then CLEAR
    for (int i = 0; i < 16; i++) quiet(LD, 4'(i), 4'd0, 4'd0, 1'b0, 6'(i + 1));
    cmd("dsp_r15_pre", DSP, 4'd0, 4'd15, 4'd0, 1'b0, 6'd0, 4'd15, 16'd16, 1'b0, 5);
    cmd("clear", CLR, 4'd9, 4'd9, 4'd9, 1'b0, 6'd0, 4'd0, 16'd0, 1'b0, 20);
    cmd("dsp_r0_clr", DSP, 4'd0, 4'd0, 4'd0, 1'b0, 6'd0, 4'd0, 16'd0, 1'b0, 5);
    cmd("dsp_r15_clr", DSP, 4'd0, 4'd15, 4'd0, 1'b0, 6'd0, 4'd15, 16'd0, 1'b0, 5);

    // Stalled display handshake with an ignored strobe
    disp_ready = 1'b0;
    issue(LD, 4'd2, 4'd0, 4'd0, 1'b0, 6'd9, 0);
    repeat (3) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", disp_valid, 1);
      chk("stall_val", disp_value, 16'd9);
      chk("stall_reg", disp_reg, 2);
      chk("stall_op", disp_op, 0);
      chk("stall_sd", store_done, 0);
      if (i == 2) begin
        alu_func = LD; DEST = 4'd2; IMM_SIGN = 1'b1; IMM_MAGNETUDE = 6'd1; alu_enable = 1'b1;
      end else begin
        alu_enable = 1'b0;
      end
      @(negedge clk);
    end
    alu_enable = 1'b0;
    chk("stall_valid_end", disp_valid, 1);
    disp_ready = 1'b1;
    @(negedge clk);
    chk("stall_sd_after", store_done, 1);
    chk("stall_valid_drop", disp_valid, 0);
    @(negedge clk);
    chk("stall_sd_once", store_done, 0);
    chk("stall_idle", busy, 0);
    @(negedge clk);
    chk("stall_no_restart", busy, 0);
    cmd("dsp_r2_stall", DSP, 4'd0, 4'd2, 4'd0, 1'b0, 6'd0, 4'd2, 16'd9, 1'b0, 5);

    // Asynchronous reset mid-ADD (record currently holds DISPLAY r2 = 9)
    issue(ADD, 4'd3, 4'd2, 4'd2, 1'b0, 6'd0, 2);
    @(negedge clk);
    chk("mid_busy", busy, 1);
    #2 rst = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_valid", disp_valid, 0);
    chk("arst_sd", store_done, 0);
    chk("arst_op", disp_op, 0);
    chk("arst_reg", disp_reg, 0);
    chk("arst_val", disp_value, 0);
    chk("arst_ovf", disp_ovf, 0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("arst_no_sd", store_done, 0);
    end
    cmd("dsp_r2_rst", DSP, 4'd0, 4'd2, 4'd0, 1'b0, 6'd0, 4'd2, 16'd0, 1'b0, 5);
    quiet(LD, 4'd4, 4'd0, 4'd0, 1'b0, 6'd5);
    cmd("add_after_rst", ADD, 4'd5, 4'd4, 4'd4, 1'b0, 6'd0, 4'd5, 16'd10, 1'b0, 5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
